// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray conversion, address sizing and
// parameter legality.
package fifo_pkg;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Pointers carry AW+1 bits through 32-bit helpers, so depth is capped at 2**30.
    function automatic bit params_legal(input int width, input int depth,
                                        input int af, input int ae);
        return (width >= 1) && (depth >= 4) && (depth <= (1 << 30)) &&
               ((depth & (depth - 1)) == 0) &&
               (af >= 1) && (af <= depth - 1) &&
               (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/gray_sync_bus.sv
// Two-flop synchroniser for a Gray-coded pointer bus, cleared by the async reset.
module gray_sync_bus #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/async_fifo_param.sv
// Parametrised dual-clock FIFO on a flop array, with optional first-word-fall-through
// output, conservative occupancy counts, almost flags and sticky error flags.
module async_fifo_param
    import fifo_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int DEPTH     = 64,
    parameter  int FWFT      = 0,
    parameter  int AF_MARGIN = 4,
    parameter  int AE_MARGIN = 4,
    localparam int AW        = addr_width(DEPTH)
) (
    input  logic             wclk,
    input  logic             rclk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [WIDTH-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    output logic [AW:0]      wcount,
    output logic             woverflow,
    input  logic             rinc,
    output logic [WIDTH-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [AW:0]      rcount,
    output logic             runderflow
);

    localparam int CW = AW + 1;
    localparam logic [AW:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);
    localparam logic [AW:0] AE_LEVEL = CW'(AE_MARGIN);

    if (!params_legal(WIDTH, DEPTH, AF_MARGIN, AE_MARGIN)) begin : g_bad_params
        $error("async_fifo_param: illegal WIDTH/DEPTH/AF_MARGIN/AE_MARGIN combination");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0] wbin, wgray, rgray_sync;
    logic [AW:0] wbin_next, wgray_next, wcount_next;
    logic        wen, wfull_next;

    logic [AW:0] rbin, rgray, wgray_sync;
    logic [AW:0] rbin_next, rgray_next, rcount_next;
    logic        fetch, store_avail, out_valid, ov_next, rempty_next;

    gray_sync_bus #(.WIDTH(CW)) u_sync_r2w (
        .clk   (wclk),
        .rst_n (rst_n),
        .d     (rgray),
        .q     (rgray_sync)
    );

    gray_sync_bus #(.WIDTH(CW)) u_sync_w2r (
        .clk   (rclk),
        .rst_n (rst_n),
        .d     (wgray),
        .q     (wgray_sync)
    );

    assign wen         = winc && !wfull;
    assign wbin_next   = wbin + CW'(wen);
    assign wgray_next  = CW'(bin2gray(32'(wbin_next)));
    assign wcount_next = wbin_next - CW'(gray2bin(32'(rgray_sync)));
    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
    assign wfull_next  = (wgray_next == {~rgray_sync[AW:AW-1], rgray_sync[AW-2:0]});

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wbin         <= '0;
            wgray        <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wcount       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wgray        <= wgray_next;
            wfull        <= wfull_next;
            walmost_full <= (wcount_next >= AF_LEVEL);
            wcount       <= wcount_next;
            woverflow    <= woverflow | (winc && wfull);
        end
    end

    always_ff @(posedge wclk) begin
        if (wen) begin
            mem[wbin[AW-1:0]] <= wdata;
        end
    end

    // In FWFT mode the output register refills from storage whenever it is empty or
    // being consumed; the live compare against the synchronised pointer is safe.
    assign store_avail = (rgray != wgray_sync);
    assign fetch       = (FWFT != 0) ? (store_avail && (!out_valid || rinc))
                                     : (rinc && !rempty);
    assign ov_next     = (FWFT != 0) && (fetch || (out_valid && !rinc));
    assign rbin_next   = rbin + CW'(fetch);
    assign rgray_next  = CW'(bin2gray(32'(rbin_next)));
    assign rempty_next = (FWFT != 0) ? !ov_next : (rgray_next == wgray_sync);
    assign rcount_next = CW'(gray2bin(32'(wgray_sync))) - rbin_next + CW'(ov_next);

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            rbin          <= '0;
            rgray         <= '0;
            out_valid     <= 1'b0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rcount        <= '0;
            runderflow    <= 1'b0;
            rdata         <= '0;
        end else begin
            rbin          <= rbin_next;
            rgray         <= rgray_next;
            out_valid     <= ov_next;
            rempty        <= rempty_next;
            ralmost_empty <= (rcount_next <= AE_LEVEL);
            rcount        <= rcount_next;
            runderflow    <= runderflow | (rinc && rempty);
            if (fetch) begin
                rdata <= mem[rbin[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_param.sv
// Self-checking bench: standard and FWFT instances driven from shared stimulus.
`timescale 1ns/1ps
module tb_async_fifo_param;

    logic       wclk = 1'b0;
    logic       rclk = 1'b0;
    logic       rst_n = 1'b1;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic       wfull0, walmost_full0, woverflow0, rempty0, ralmost_empty0, runderflow0;
    logic [4:0] wcount0, rcount0;
    logic [7:0] rdata0;
    logic       wfull1, walmost_full1, woverflow1, rempty1, ralmost_empty1, runderflow1;
    logic [4:0] wcount1, rcount1;
    logic [7:0] rdata1;

    realtime whalf = 5.0;
    realtime rhalf = 13.5;

    int checks = 0;
    int failures = 0;
    bit both_mon = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       winc;
        logic [7:0] wdata;
        logic       exp_wfull;
        logic       exp_walmost_full;
        logic       exp_woverflow;
        logic [4:0] exp_wcount;
    } wvec_t;

    typedef struct {
        logic       exp_rempty;
        logic       exp_ralmost_empty;
        logic [4:0] exp_rcount;
    } rvec_t;

    wvec_t wtab[17];
    rvec_t rtab[16];

    async_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_MARGIN(4), .AE_MARGIN(2)) dut0 (
        .wclk(wclk), .rclk(rclk), .rst_n(rst_n), .winc(winc), .wdata(wdata),
        .wfull(wfull0), .walmost_full(walmost_full0), .wcount(wcount0), .woverflow(woverflow0),
        .rinc(rinc), .rdata(rdata0), .rempty(rempty0), .ralmost_empty(ralmost_empty0),
        .rcount(rcount0), .runderflow(runderflow0)
    );

    async_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AF_MARGIN(4), .AE_MARGIN(2)) dut1 (
        .wclk(wclk), .rclk(rclk), .rst_n(rst_n), .winc(winc), .wdata(wdata),
        .wfull(wfull1), .walmost_full(walmost_full1), .wcount(wcount1), .woverflow(woverflow1),
        .rinc(rinc), .rdata(rdata1), .rempty(rempty1), .ralmost_empty(ralmost_empty1),
        .rcount(rcount1), .runderflow(runderflow1)
    );

    initial forever #(whalf) wclk = ~wclk;
    initial forever #(rhalf) rclk = ~rclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flag/count consistency that holds for every legal cycle in both read modes.
    always @(negedge wclk) begin
        check("wfull0_vs_wcount", wfull0, wcount0 == 5'd16);
        check("walmost_full0_vs_wcount", walmost_full0, wcount0 >= 5'd12);
        check("wfull1_vs_wcount", wfull1, wcount1 == 5'd16);
        check("walmost_full1_vs_wcount", walmost_full1, wcount1 >= 5'd12);
        if (both_mon) check("full_and_empty_together", wfull0 & rempty0, 1'b0);
    end

    always @(negedge rclk) begin
        check("rempty0_vs_rcount", rempty0, rcount0 == 5'd0);
        check("ralmost_empty0_vs_rcount", ralmost_empty0, rcount0 <= 5'd2);
        check("rempty1_vs_rcount", rempty1, rcount1 == 5'd0);
        check("ralmost_empty1_vs_rcount", ralmost_empty1, rcount1 <= 5'd2);
    end

    task automatic reset_state_checks(input string tag);
        check({tag, "_wfull"}, wfull0, 1'b0);
        check({tag, "_walmost_full"}, walmost_full0, 1'b0);
        check({tag, "_wcount"}, wcount0, 5'd0);
        check({tag, "_woverflow"}, woverflow0, 1'b0);
        check({tag, "_rempty"}, rempty0, 1'b1);
        check({tag, "_ralmost_empty"}, ralmost_empty0, 1'b1);
        check({tag, "_rcount"}, rcount0, 5'd0);
        check({tag, "_runderflow"}, runderflow0, 1'b0);
        check({tag, "_rdata"}, rdata0, 8'h00);
        check({tag, "_fwft_rempty"}, rempty1, 1'b1);
        check({tag, "_fwft_rdata"}, rdata1, 8'h00);
    endtask

    task automatic reset_pulse();
        #0.3;
        rst_n = 1'b0;
        #20;
        rst_n = 1'b1;
        #0.7;
    endtask

    task automatic write_word(input logic [7:0] d);
        winc = 1'b1;
        wdata = d;
        @(posedge wclk);
        #1;
        winc = 1'b0;
    endtask

    task automatic read_pulse();
        rinc = 1'b1;
        @(posedge rclk);
        #1;
        rinc = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] e;

        for (int i = 0; i < 17; i++) begin
            int cnt;
            cnt = (i < 16) ? i + 1 : 16;
            wtab[i].winc             = 1'b1;
            wtab[i].wdata            = (i < 16) ? 8'(i) : 8'hAA;
            wtab[i].exp_wcount       = 5'(cnt);
            wtab[i].exp_wfull        = (cnt == 16);
            wtab[i].exp_walmost_full = (cnt >= 12);
            wtab[i].exp_woverflow    = (i == 16);
        end
        for (int j = 0; j < 16; j++) begin
            rtab[j].exp_rcount        = 5'(15 - j);
            rtab[j].exp_ralmost_empty = ((15 - j) <= 2);
            rtab[j].exp_rempty        = (j == 15);
        end

        #1;
        rst_n = 1'b0;
        #2;
        reset_state_checks("reset");
        #38.3;
        rst_n = 1'b1;

        // Underflow on an empty FIFO.
        @(posedge rclk);
        #1;
        rinc = 1'b1;
        repeat (5) @(posedge rclk);
        #1;
        rinc = 1'b0;
        check("underflow_flag", runderflow0, 1'b1);
        check("underflow_rdata", rdata0, 8'h00);
        check("underflow_rcount", rcount0, 5'd0);
        check("underflow_rempty", rempty0, 1'b1);
        check("underflow_fwft_flag", runderflow1, 1'b1);
        check("underflow_fwft_rdata", rdata1, 8'h00);

        // Fill to full, then one dropped write.
        reset_pulse();
        @(posedge wclk);
        #1;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(wtab[i].wdata);
            winc = wtab[i].winc;
            wdata = wtab[i].wdata;
            @(posedge wclk);
            #1;
            winc = 1'b0;
            check("fill_wfull", wfull0, wtab[i].exp_wfull);
            check("fill_wcount", wcount0, wtab[i].exp_wcount);
            check("fill_walmost_full", walmost_full0, wtab[i].exp_walmost_full);
            check("fill_woverflow", woverflow0, wtab[i].exp_woverflow);
        end

        n = 0;
        while (rcount0 != 5'd16 && n < 10) begin
            @(posedge rclk);
            #1;
            n++;
        end
        check("full_rcount", rcount0, 5'd16);
        check("full_ralmost_empty", ralmost_empty0, 1'b0);
        check("full_rempty", rempty0, 1'b0);

        @(posedge rclk);
        #1;
        for (int j = 0; j < 16; j++) begin
            rinc = 1'b1;
            @(posedge rclk);
            #1;
            e = exp_q.pop_front();
            check("drain_rdata", rdata0, e);
            check("drain_rcount", rcount0, rtab[j].exp_rcount);
            check("drain_ralmost_empty", ralmost_empty0, rtab[j].exp_ralmost_empty);
            check("drain_rempty", rempty0, rtab[j].exp_rempty);
        end
        rinc = 1'b0;
        read_pulse();
        check("drained_underflow", runderflow0, 1'b1);
        check("drained_rdata_hold", rdata0, 8'h0F);

        // Reset mid-stream with 10 entries stored and both sticky flags set.
        @(posedge wclk);
        #1;
        for (int i = 0; i < 10; i++) write_word(8'(8'h30 + i));
        repeat (4) @(posedge rclk);
        #1;
        check("pre_reset_wcount", wcount0, 5'd10);
        check("pre_reset_rcount", rcount0, 5'd10);
        check("pre_reset_woverflow", woverflow0, 1'b1);
        rst_n = 1'b0;
        #1;
        reset_state_checks("midreset");
        #20.3;
        rst_n = 1'b1;
        @(posedge wclk);
        #1;
        exp_q.push_back(8'h77);
        write_word(8'h77);
        n = 0;
        while (rempty0 && n < 10) begin
            @(posedge rclk);
            #1;
            n++;
        end
        check("post_reset_rempty", rempty0, 1'b0);
        check("post_reset_rcount", rcount0, 5'd1);
        read_pulse();
        e = exp_q.pop_front();
        check("post_reset_rdata", rdata0, e);

        // First-word-fall-through.
        reset_pulse();
        @(posedge wclk);
        #1;
        winc = 1'b1;
        wdata = 8'h5A;
        @(posedge wclk);
        #0.1;
        winc = 1'b0;
        n = 0;
        while (n < 6) begin
            @(posedge rclk);
            n++;
            #1;
            if (!rempty1) break;
        end
        check("fwft_latency_within_4", n <= 4, 1'b1);
        check("fwft_rdata_before_rinc", rdata1, 8'h5A);
        check("fwft_rcount_one", rcount1, 5'd1);
        read_pulse();
        check("fwft_empty_after_consume", rempty1, 1'b1);
        check("fwft_rcount_zero", rcount1, 5'd0);

        @(posedge wclk);
        #1;
        write_word(8'h11);
        write_word(8'h22);
        n = 0;
        while (rcount1 != 5'd2 && n < 10) begin
            @(posedge rclk);
            #1;
            n++;
        end
        check("fwft_two_rempty", rempty1, 1'b0);
        check("fwft_two_head", rdata1, 8'h11);
        read_pulse();
        check("fwft_next_word", rdata1, 8'h22);
        check("fwft_next_rempty", rempty1, 1'b0);
        check("fwft_next_rcount", rcount1, 5'd1);
        read_pulse();
        check("fwft_final_rempty", rempty1, 1'b1);
        check("fwft_no_underflow", runderflow1, 1'b0);

        // Wrap-around with mismatched clocks.
        whalf = 3.5;
        rhalf = 6.5;
        reset_pulse();
        exp_q.delete();
        both_mon = 1'b1;
        fork
            begin : writer
                int g;
                int w;
                @(posedge wclk);
                #1;
                for (int i = 0; i < 40; i++) begin
                    g = $urandom_range(0, 2);
                    repeat (g) begin
                        @(posedge wclk);
                        #1;
                    end
                    w = 0;
                    while (wfull0 && w < 200) begin
                        @(posedge wclk);
                        #1;
                        w++;
                    end
                    if (w >= 200) begin
                        check("wrap_wfull_timeout", wfull0, 1'b0);
                        break;
                    end
                    exp_q.push_back(8'(i * 37 + 5));
                    write_word(8'(i * 37 + 5));
                end
            end
            begin : reader
                int got;
                int cyc;
                logic did;
                got = 0;
                cyc = 0;
                did = 1'b0;
                while (got < 40 && cyc < 1500) begin
                    @(posedge rclk);
                    #1;
                    cyc++;
                    if (did) begin
                        if (exp_q.size() == 0) begin
                            check("wrap_unexpected_read", 1'b1, 1'b0);
                        end else begin
                            e = exp_q.pop_front();
                            check("wrap_data", rdata0, e);
                        end
                        got++;
                    end
                    did = !rempty0 && ($urandom_range(0, 3) != 0);
                    rinc = did;
                end
                rinc = 1'b0;
                check("wrap_read_count", got, 40);
            end
        join
        both_mon = 1'b0;
        check("wrap_queue_drained", exp_q.size(), 0);
        check("wrap_no_underflow", runderflow0, 1'b0);
        check("wrap_no_overflow", woverflow0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
